// File: rtl/nv_nvdla_mcif_wr_pkg.sv
// Shared definitions for the MCIF write path: context-queue payload layout,
// AXI id/len widths and client id encodings.
package nv_nvdla_mcif_wr_pkg;

   localparam int CQ_PD_W       = 3;
   localparam int CQ_PD_ACK     = 0;
   localparam int CQ_PD_LEN_LSB = 1;
   localparam int CQ_PD_LEN_MSB = 2;

   localparam int AXI_ID_W    = 8;
   localparam int AXI_LEN_W   = 4;
   localparam int CLIENT_ID_W = 3;
   localparam int REQ_LEN_W   = 2;

   typedef enum logic [CLIENT_ID_W-1:0] {
      CLIENT_BDMA = 3'd0,
      CLIENT_SDP  = 3'd1,
      CLIENT_PDP  = 3'd2,
      CLIENT_CDP  = 3'd3,
      CLIENT_RBK  = 3'd4
   } client_id_e;

   function automatic logic [CQ_PD_W-1:0] cq_pd_pack(input logic [REQ_LEN_W-1:0] len,
                                                     input logic                 ack);
      logic [CQ_PD_W-1:0] pd;
      pd = '0;
      pd[CQ_PD_ACK]                   = ack;
      pd[CQ_PD_LEN_MSB:CQ_PD_LEN_LSB] = len;
      return pd;
   endfunction

endpackage

// File: rtl/nv_nvdla_mcif_wr_aw_pipe.sv
// One-entry AXI AW output register; a pop in the same cycle frees the slot
// for a new load, so back-to-back issue runs at one beat per cycle.
module nv_nvdla_mcif_wr_aw_pipe
   import nv_nvdla_mcif_wr_pkg::*;
#(
   parameter int AW_ADDR_W = 64
) (
   input  logic                   nvdla_core_clk,
   input  logic                   nvdla_core_rstn,
   input  logic                   in_vld,
   output logic                   in_rdy,
   input  logic [CLIENT_ID_W-1:0] in_id,
   input  logic [AW_ADDR_W-1:0]   in_addr,
   input  logic [REQ_LEN_W-1:0]   in_len,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic [AXI_ID_W-1:0]    out_id,
   output logic [AW_ADDR_W-1:0]   out_addr,
   output logic [AXI_LEN_W-1:0]   out_len
);

   logic                   vld_q,  vld_d;
   logic [CLIENT_ID_W-1:0] id_q,   id_d;
   logic [AW_ADDR_W-1:0]   addr_q, addr_d;
   logic [REQ_LEN_W-1:0]   len_q,  len_d;
   logic                   load;

   assign in_rdy = !vld_q | out_rdy;
   assign load   = in_vld & in_rdy;

   // Payload only moves on a load, so it is stable while waiting on awready.
   always_comb begin
      vld_d  = vld_q;
      id_d   = id_q;
      addr_d = addr_q;
      len_d  = len_q;
      if (load) begin
         vld_d  = 1'b1;
         id_d   = in_id;
         addr_d = in_addr;
         len_d  = in_len;
      end else if (out_rdy) begin
         vld_d  = 1'b0;
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         vld_q  <= 1'b0;
         id_q   <= '0;
         addr_q <= '0;
         len_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         id_q   <= id_d;
         addr_q <= addr_d;
         len_q  <= len_d;
      end
   end

   assign out_vld  = vld_q;
   assign out_id   = {{(AXI_ID_W-CLIENT_ID_W){1'b0}}, id_q};
   assign out_addr = addr_q;
   assign out_len  = {{(AXI_LEN_W-REQ_LEN_W){1'b0}}, len_q};

endmodule

// File: rtl/nv_nvdla_mcif_write_ig_cq_os.sv
// MCIF write-ingress issue stage: context-queue push, AW issue and outstanding
// beat credit. Optional statistics are built with NVDLA_MCIF_WR_OS_STAT_EN.
module nv_nvdla_mcif_write_ig_cq_os
   import nv_nvdla_mcif_wr_pkg::*;
#(
   parameter int AW_ADDR_W = 64,
   parameter int OS_CNT_W  = 9
) (
   input  logic                   nvdla_core_clk,
   input  logic                   nvdla_core_rstn,
   input  logic                   req_pvld,
   output logic                   req_prdy,
   input  logic [2:0]             req_id,
   input  logic [AW_ADDR_W-1:0]   req_addr,
   input  logic [1:0]             req_len,
   input  logic                   req_require_ack,
   output logic                   cq_wr_pvld,
   input  logic                   cq_wr_prdy,
   output logic [2:0]             cq_wr_thread_id,
   output logic [2:0]             cq_wr_pd,
   output logic                   mcif2noc_axi_aw_awvalid,
   input  logic                   mcif2noc_axi_aw_awready,
   output logic [7:0]             mcif2noc_axi_aw_awid,
   output logic [AW_ADDR_W-1:0]   mcif2noc_axi_aw_awaddr,
   output logic [3:0]             mcif2noc_axi_aw_awlen,
   input  logic                   eg2ig_axi_vld,
   input  logic [1:0]             eg2ig_axi_len,
   input  logic [7:0]             reg2dp_wr_os_cnt,
   output logic [OS_CNT_W-1:0]    os_cnt_cur,
   output logic [31:0]            dp2reg_wr_stall_cnt,
   output logic [OS_CNT_W-1:0]    dp2reg_wr_os_max
);

   // One extra bit keeps os_cnt + beats from wrapping near the 256 limit.
   localparam int SUM_W = OS_CNT_W + 1;

   logic [OS_CNT_W-1:0] os_cnt_q, os_cnt_d;
   logic [SUM_W-1:0]    req_beats, ret_beats, limit;
   logic [SUM_W-1:0]    inc, dec, os_sum, os_diff;
   logic                os_ok, aw_room, accept, os_underflow;

   assign req_beats = {{(SUM_W-REQ_LEN_W){1'b0}}, req_len} + 1'b1;
   assign ret_beats = {{(SUM_W-REQ_LEN_W){1'b0}}, eg2ig_axi_len} + 1'b1;
   assign limit     = {{(SUM_W-8){1'b0}}, reg2dp_wr_os_cnt} + 1'b1;
   assign os_ok     = ({1'b0, os_cnt_q} + req_beats) <= limit;

   assign cq_wr_pvld      = req_pvld & os_ok & aw_room;
   assign req_prdy        = os_ok & aw_room & cq_wr_prdy;
   assign accept          = req_pvld & req_prdy;
   assign cq_wr_thread_id = req_id;
   assign cq_wr_pd        = cq_pd_pack(req_len, req_require_ack);

   always_comb begin
      inc          = accept        ? req_beats : '0;
      dec          = eg2ig_axi_vld ? ret_beats : '0;
      os_sum       = {1'b0, os_cnt_q} + inc;
      os_underflow = dec > os_sum;
      os_diff      = os_sum - dec;
      os_cnt_d     = os_underflow ? '0 : os_diff[OS_CNT_W-1:0];
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) os_cnt_q <= '0;
      else                  os_cnt_q <= os_cnt_d;
   end

   assign os_cnt_cur = os_cnt_q;

`ifdef ASSERT_ON
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rstn) begin
         nv_assert_os_underflow: assert (!os_underflow);
      end
   end
`endif

   nv_nvdla_mcif_wr_aw_pipe #(
      .AW_ADDR_W (AW_ADDR_W)
   ) u_aw_pipe (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .in_vld          (accept),
      .in_rdy          (aw_room),
      .in_id           (req_id),
      .in_addr         (req_addr),
      .in_len          (req_len),
      .out_vld         (mcif2noc_axi_aw_awvalid),
      .out_rdy         (mcif2noc_axi_aw_awready),
      .out_id          (mcif2noc_axi_aw_awid),
      .out_addr        (mcif2noc_axi_aw_awaddr),
      .out_len         (mcif2noc_axi_aw_awlen)
   );

`ifdef NVDLA_MCIF_WR_OS_STAT_EN
   logic [31:0]         stall_cnt_q, stall_cnt_d;
   logic [OS_CNT_W-1:0] os_max_q,    os_max_d;

   // Watermark follows the next count so it is current in the same cycle as os_cnt_cur.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (req_pvld && !os_ok && (stall_cnt_q != 32'hffff_ffff)) stall_cnt_d = stall_cnt_q + 1'b1;
      os_max_d = (os_cnt_d > os_max_q) ? os_cnt_d : os_max_q;
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         stall_cnt_q <= '0;
         os_max_q    <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         os_max_q    <= os_max_d;
      end
   end

   assign dp2reg_wr_stall_cnt = stall_cnt_q;
   assign dp2reg_wr_os_max    = os_max_q;
`else
   assign dp2reg_wr_stall_cnt = '0;
   assign dp2reg_wr_os_max    = '0;
`endif

endmodule

// File: tb/tb_nv_nvdla_mcif_write_ig_cq_os.sv
// Directed bench for the MCIF write-ingress issue stage: cq push, AW issue,
// credit accounting, back-pressure and optional statistics.
module tb_nv_nvdla_mcif_write_ig_cq_os;

   logic        nvdla_core_clk = 1'b0;
   logic        nvdla_core_rstn;
   logic        req_pvld, req_prdy;
   logic [2:0]  req_id;
   logic [63:0] req_addr;
   logic [1:0]  req_len;
   logic        req_require_ack;
   logic        cq_wr_pvld, cq_wr_prdy;
   logic [2:0]  cq_wr_thread_id, cq_wr_pd;
   logic        awvalid, awready;
   logic [7:0]  awid;
   logic [63:0] awaddr;
   logic [3:0]  awlen;
   logic        eg2ig_axi_vld;
   logic [1:0]  eg2ig_axi_len;
   logic [7:0]  reg2dp_wr_os_cnt;
   logic [8:0]  os_cnt_cur, os_max;
   logic [31:0] stall_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 nvdla_core_clk = ~nvdla_core_clk;

   nv_nvdla_mcif_write_ig_cq_os #(.AW_ADDR_W(64), .OS_CNT_W(9)) dut (
      .nvdla_core_clk          (nvdla_core_clk),
      .nvdla_core_rstn         (nvdla_core_rstn),
      .req_pvld                (req_pvld),
      .req_prdy                (req_prdy),
      .req_id                  (req_id),
      .req_addr                (req_addr),
      .req_len                 (req_len),
      .req_require_ack         (req_require_ack),
      .cq_wr_pvld              (cq_wr_pvld),
      .cq_wr_prdy              (cq_wr_prdy),
      .cq_wr_thread_id         (cq_wr_thread_id),
      .cq_wr_pd                (cq_wr_pd),
      .mcif2noc_axi_aw_awvalid (awvalid),
      .mcif2noc_axi_aw_awready (awready),
      .mcif2noc_axi_aw_awid    (awid),
      .mcif2noc_axi_aw_awaddr  (awaddr),
      .mcif2noc_axi_aw_awlen   (awlen),
      .eg2ig_axi_vld           (eg2ig_axi_vld),
      .eg2ig_axi_len           (eg2ig_axi_len),
      .reg2dp_wr_os_cnt        (reg2dp_wr_os_cnt),
      .os_cnt_cur              (os_cnt_cur),
      .dp2reg_wr_stall_cnt     (stall_cnt),
      .dp2reg_wr_os_max        (os_max)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; registered outputs are settled then.
   task automatic tick();
      @(posedge nvdla_core_clk);
      #1;
   endtask

   task automatic set_req(input logic [2:0] id, input logic [63:0] addr,
                          input logic [1:0] len, input logic ack);
      req_pvld        = 1'b1;
      req_id          = id;
      req_addr        = addr;
      req_len         = len;
      req_require_ack = ack;
   endtask

   task automatic ret(input logic [1:0] len);
      eg2ig_axi_vld = 1'b1;
      eg2ig_axi_len = len;
      tick();
      eg2ig_axi_vld = 1'b0;
   endtask

   initial begin
      nvdla_core_rstn  = 1'b0;
      req_pvld         = 1'b0;
      req_id           = '0;
      req_addr         = '0;
      req_len          = '0;
      req_require_ack  = 1'b0;
      cq_wr_prdy       = 1'b0;
      awready          = 1'b0;
      eg2ig_axi_vld    = 1'b0;
      eg2ig_axi_len    = '0;
      reg2dp_wr_os_cnt = 8'hff;
      repeat (3) tick();

      chk("rst_prdy",    req_prdy,   0);
      chk("rst_cq_pvld", cq_wr_pvld, 0);
      chk("rst_awvalid", awvalid,    0);
      chk("rst_awid",    awid,       0);
      chk("rst_awaddr",  awaddr,     0);
      chk("rst_awlen",   awlen,      0);
      chk("rst_os",      os_cnt_cur, 0);
      chk("rst_stall",   stall_cnt,  0);
      chk("rst_osmax",   os_max,     0);

      nvdla_core_rstn = 1'b1;
      cq_wr_prdy      = 1'b1;
      awready         = 1'b1;
      tick();

      // single request: cq push same cycle, AW one cycle later
      set_req(3'd1, 64'h1000, 2'd3, 1'b1);
      #1;
      chk("t1_cq_pvld", cq_wr_pvld,      1);
      chk("t1_cq_tid",  cq_wr_thread_id, 1);
      chk("t1_cq_pd",   cq_wr_pd,        3'b111);
      chk("t1_prdy",    req_prdy,        1);
      chk("t1_aw_pre",  awvalid,         0);
      tick();
      req_pvld = 1'b0;
      chk("t1_awvalid", awvalid, 1);
      chk("t1_awid",    awid,    8'h01);
      chk("t1_awlen",   awlen,   3);
      chk("t1_awaddr",  awaddr,  64'h1000);
      chk("t1_os",      os_cnt_cur, 4);
      tick();
      chk("t1_aw_pop",  awvalid, 0);
      ret(2'd3);
      chk("t1_os_ret",  os_cnt_cur, 0);

      // credit limit 8: two len-3 requests fill it, third waits for a return
      reg2dp_wr_os_cnt = 8'd7;
      set_req(3'd2, 64'h2000, 2'd3, 1'b0);
      tick();
      set_req(3'd2, 64'h2040, 2'd3, 1'b0);
      #1;
      chk("t2_prdy2", req_prdy, 1);
      tick();
      set_req(3'd2, 64'h2080, 2'd3, 1'b0);
      #1;
      chk("t2_os8",     os_cnt_cur, 8);
      chk("t2_stall",   req_prdy,   0);
      chk("t2_cq_hold", cq_wr_pvld, 0);
      repeat (3) tick();
      chk("t2_stall3",  req_prdy,   0);
      chk("t2_os_hold", os_cnt_cur, 8);
      eg2ig_axi_vld = 1'b1;
      eg2ig_axi_len = 2'd3;
      #1;
      chk("t2_ret_cyc", req_prdy, 0);
      tick();
      eg2ig_axi_vld = 1'b0;
      #1;
      chk("t2_os4",    os_cnt_cur, 4);
      chk("t2_prdy3",  req_prdy,   1);
      tick();
      req_pvld = 1'b0;
      chk("t2_os8b",   os_cnt_cur, 8);
      chk("t2_awaddr", awaddr,     64'h2080);
      ret(2'd3);
      ret(2'd3);
      chk("t2_drain",  os_cnt_cur, 0);
      reg2dp_wr_os_cnt = 8'hff;

      // stray return with nothing outstanding saturates at zero
      ret(2'd3);
      chk("sat_zero", os_cnt_cur, 0);

      // simultaneous accept (len 1) and return (len 3) from os=4
      set_req(3'd0, 64'h3000, 2'd3, 1'b0);
      tick();
      set_req(3'd0, 64'h3100, 2'd1, 1'b0);
      eg2ig_axi_vld = 1'b1;
      eg2ig_axi_len = 2'd3;
      tick();
      req_pvld      = 1'b0;
      eg2ig_axi_vld = 1'b0;
      chk("t3_net", os_cnt_cur, 2);
      ret(2'd1);
      chk("t3_drain", os_cnt_cur, 0);

      // awready low: one AW held stable, no further accept or cq push
      awready = 1'b0;
      set_req(3'd3, 64'h4000, 2'd0, 1'b1);
      tick();
      set_req(3'd4, 64'h5000, 2'd1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t4_prdy",    req_prdy,   0);
         chk("t4_cq_pvld", cq_wr_pvld, 0);
         chk("t4_awvalid", awvalid,    1);
         chk("t4_awaddr",  awaddr,     64'h4000);
         chk("t4_awid",    awid,       8'h03);
         tick();
      end
      chk("t4_os1", os_cnt_cur, 1);
      awready = 1'b1;
      #1;
      chk("t4_prdy_pop", req_prdy, 1);
      tick();
      req_pvld = 1'b0;
      chk("t4_awid2",   awid,   8'h04);
      chk("t4_awaddr2", awaddr, 64'h5000);
      chk("t4_awlen2",  awlen,  1);
      tick();
      chk("t4_aw_done", awvalid,    0);
      chk("t4_os3",     os_cnt_cur, 3);
      ret(2'd2);
      chk("t4_drain",   os_cnt_cur, 0);

      // cq back-pressure: pvld shown, nothing accepted
      cq_wr_prdy = 1'b0;
      set_req(3'd1, 64'h6000, 2'd2, 1'b1);
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("t5_cq_pvld", cq_wr_pvld, 1);
         chk("t5_prdy",    req_prdy,   0);
         tick();
         chk("t5_awvalid", awvalid,    0);
         chk("t5_os",      os_cnt_cur, 0);
      end
      req_pvld   = 1'b0;
      cq_wr_prdy = 1'b1;

      // statistics: fresh reset, limit 4, fill it, then 10 credit-stall cycles
      nvdla_core_rstn = 1'b0;
      tick();
      nvdla_core_rstn = 1'b1;
      tick();
      reg2dp_wr_os_cnt = 8'd3;
      set_req(3'd1, 64'h7000, 2'd3, 1'b0);
      tick();
      set_req(3'd1, 64'h7100, 2'd0, 1'b0);
      repeat (10) tick();
      req_pvld = 1'b0;
      #1;
      chk("st_os", os_cnt_cur, 4);
`ifdef NVDLA_MCIF_WR_OS_STAT_EN
      chk("st_stall", stall_cnt, 10);
      chk("st_osmax", os_max,    4);
`else
      chk("st_stall", stall_cnt, 0);
      chk("st_osmax", os_max,    0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
